// File: rtl/sobel_stream_if.sv
// -----------------------------------------------------------------------------
// sobel_stream_if
//   Valid/ready pixel stream used on both sides of sobel_stream.
//   Signals:
//     valid  producer -> consumer  data is valid this cycle
//     ready  consumer -> producer  consumer accepts data this cycle
//     data   producer -> consumer  PIX_WIDTH-bit unsigned pixel
//   Modports:
//     master  drives valid/data, observes ready
//     slave   observes valid/data, drives ready
// -----------------------------------------------------------------------------
interface sobel_stream_if #(
  parameter int PIX_WIDTH = 8
) ();
  logic                 valid;
  logic                 ready;
  logic [PIX_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sobel_stream.sv
// -----------------------------------------------------------------------------
// sobel_stream
//   Streaming 3x3 Sobel edge detector for raster video. Two line buffers and a
//   two-column window register build the 3x3 neighbourhood; the third window
//   column is taken straight from the line-buffer read ports and the incoming
//   pixel. Only interior pixels produce an output, giving an
//   (IMG_HEIGHT-2) x (IMG_WIDTH-2) gradient image.
//
//   Optional feature macro: SOBEL_THRESH_EN
//     defined   -> threshold port present, out data is binary (all-ones/zero)
//     undefined -> out data is the saturated gradient magnitude
//
//   Ports:
//     clock       rising-edge clock
//     reset       synchronous, active-high
//     in_s        pixel input stream (slave), raster order
//     out_m       gradient output stream (master), single register stage
//     threshold   edge threshold (only with SOBEL_THRESH_EN)
//     frame_done  one-cycle pulse the cycle after the last pixel is accepted
// -----------------------------------------------------------------------------
module sobel_stream #(
  parameter int PIX_WIDTH  = 8,
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int SHIFT      = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  sobel_stream_if.slave        in_s,
  sobel_stream_if.master       out_m,
`ifdef SOBEL_THRESH_EN
  input  logic [PIX_WIDTH-1:0] threshold,
`endif
  output logic                 frame_done
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int SW    = PIX_WIDTH + 3;  // signed gradient width
  localparam int MW    = PIX_WIDTH + 4;  // unsigned magnitude width

  // Position counters
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Window columns 0 and 1; index [row][col], row 0 is the top line
  logic [2:0][1:0][PIX_WIDTH-1:0] win_q, win_d;

  // Output stage
  logic                 out_valid_q, out_valid_d;
  logic [PIX_WIDTH-1:0] out_data_q,  out_data_d;
  logic                 frame_done_q, frame_done_d;

  // Line buffers: lb1 holds the previous line, lb2 the one before it
  logic [PIX_WIDTH-1:0] lb1_mem [IMG_WIDTH];
  logic [PIX_WIDTH-1:0] lb2_mem [IMG_WIDTH];

  logic                          accept;
  logic                          produce;
  logic                          col_last;
  logic                          row_last;
  logic [2:0][PIX_WIDTH-1:0]     col2;
  logic signed [SW-1:0]          e [3][3];
  logic signed [SW-1:0]          gx, gy;
  logic [MW-1:0]                 abs_gx, abs_gy, mag;
  logic [PIX_WIDTH-1:0]          mag_sat;
  logic [PIX_WIDTH-1:0]          result;

  function automatic logic signed [SW-1:0] ext(input logic [PIX_WIDTH-1:0] p);
    return $signed({3'b000, p});
  endfunction

  // Single output register: input may advance whenever that register is
  // empty or is being drained this cycle.
  assign in_s.ready = !out_valid_q || out_m.ready;
  assign accept     = in_s.valid && in_s.ready;

  assign col_last = (col_q == COL_W'(IMG_WIDTH - 1));
  assign row_last = (row_q == ROW_W'(IMG_HEIGHT - 1));

  // Row/column gating guarantees all nine window taps belong to the current
  // frame and to three consecutive columns of the same three lines.
  assign produce  = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  // Newest window column: pixels (row-2, col), (row-1, col), (row, col)
  assign col2[0] = lb2_mem[col_q];
  assign col2[1] = lb1_mem[col_q];
  assign col2[2] = in_s.data;

  // Sobel arithmetic on the window as it stands at the accepting edge
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      e[r][0] = ext(win_q[r][0]);
      e[r][1] = ext(win_q[r][1]);
      e[r][2] = ext(col2[r]);
    end
    gx = (e[0][2] + (e[1][2] <<< 1) + e[2][2]) - (e[0][0] + (e[1][0] <<< 1) + e[2][0]);
    gy = (e[2][0] + (e[2][1] <<< 1) + e[2][2]) - (e[0][0] + (e[0][1] <<< 1) + e[0][2]);
    // The negation cannot overflow: |gx|,|gy| <= 4*(2^PIX_WIDTH-1) fits SW-1 bits.
    abs_gx  = gx[SW-1] ? MW'(-gx) : MW'(gx);
    abs_gy  = gy[SW-1] ? MW'(-gy) : MW'(gy);
    mag     = (abs_gx + abs_gy) >> SHIFT;
    mag_sat = (|mag[MW-1:PIX_WIDTH]) ? '1 : mag[PIX_WIDTH-1:0];
`ifdef SOBEL_THRESH_EN
    result  = (mag_sat >= threshold) ? '1 : '0;
`else
    result  = mag_sat;
`endif
  end

  // Next-state logic
  // NOTE: every signal gets a default at the top of an always_comb block so
  // that no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;

    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = col2[r];
      end
      frame_done_d = col_last && row_last;
    end

    // A producing accept reloads the register even while it is being
    // drained, so back-to-back outputs have no bubble.
    if (produce) begin
      out_valid_d = 1'b1;
      out_data_d  = result;
    end else if (out_m.ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: the line buffers are deliberately not reset; stale contents are
  // never used because row gating waits for two fresh lines each frame, and
  // leaving out the reset lets the arrays map onto RAM.
  always_ff @(posedge clock) begin
    if (accept) begin
      lb1_mem[col_q] <= in_s.data;
      lb2_mem[col_q] <= lb1_mem[col_q];
    end
  end

  assign out_m.valid = out_valid_q;
  assign out_m.data  = out_data_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_sobel_stream.sv
// -----------------------------------------------------------------------------
// tb_sobel_stream
//   Directed bench for sobel_stream on a 4x4 frame (PIX_WIDTH=8, SHIFT=1).
//   A table of frames with hand-computed outputs is run back to back, followed
//   by hand-written sequences for stall, frame boundary, reset and threshold.
//   Define SOBEL_THRESH_EN for both bench and RTL to exercise the binary mode.
// -----------------------------------------------------------------------------
module tb_sobel_stream;

  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int SH = 1;

  logic clock = 1'b0;
  logic reset;
  logic frame_done;
`ifdef SOBEL_THRESH_EN
  logic [PW-1:0] threshold;
`endif

  always #5 clock = ~clock;

  sobel_stream_if #(.PIX_WIDTH(PW)) in_if ();
  sobel_stream_if #(.PIX_WIDTH(PW)) out_if ();

  sobel_stream #(
    .PIX_WIDTH (PW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .SHIFT     (SH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_s      (in_if),
    .out_m     (out_if),
`ifdef SOBEL_THRESH_EN
    .threshold (threshold),
`endif
    .frame_done(frame_done)
  );

  typedef logic [0:3][PW-1:0]  row_t;
  typedef logic [0:15][PW-1:0] frame_t;

  typedef struct {
    string         name;
    frame_t        pix;
    logic [0:3][PW-1:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Output capture, sampled well after the falling edge
  logic [PW-1:0] got_q[$];
  int unsigned   got_cyc[$];
  int unsigned   acc_cyc[$];
  int            fd_cnt;
  int unsigned   fd_cyc;

  always begin
    @(negedge clock);
    #2;
    if (out_if.valid && out_if.ready) begin
      got_q.push_back(out_if.data);
      got_cyc.push_back(cyc);
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic frame_t rows(input row_t r0, input row_t r1, input row_t r2, input row_t r3);
    return {r0, r1, r2, r3};
  endfunction

  // Expected output for a hand-computed magnitude, in the configured mode
  function automatic int xf(input int m);
`ifdef SOBEL_THRESH_EN
    return (m >= int'(threshold)) ? 255 : 0;
`else
    return m;
`endif
  endfunction

  function automatic vec_t mk(input string name, input frame_t pix, input logic [PW-1:0] e);
    vec_t v;
    v.name = name;
    v.pix  = pix;
    v.exp  = {4{e}};
    return v;
  endfunction

  task automatic clear_capture();
    got_q.delete();
    got_cyc.delete();
    acc_cyc.delete();
    fd_cnt = 0;
  endtask

  // Present one pixel until accepted; k is its raster index within the frame
  task automatic send_pix(input logic [PW-1:0] d, input int k);
    bit done = 1'b0;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clock);
      in_if.valid = 1'b1;
      in_if.data  = d;
      #1;
      if (in_if.ready) begin
        done = 1'b1;
        if ((k / W) >= 2 && (k % W) >= 2) acc_cyc.push_back(cyc);
      end
    end
    if (!done) fail("send_timeout");
  endtask

  task automatic send_frame(input frame_t f, input int n);
    for (int k = 0; k < n; k++) send_pix(f[k], k);
  endtask

  task automatic go_idle();
    @(negedge clock);
    in_if.valid = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(negedge clock);
    #3;
  endtask

  task automatic check_outputs(input string name, input int n, input int exp);
    check({name, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_out%0d", name, i), (i < got_q.size()) ? int'(got_q[i]) : -1, exp);
  endtask

  localparam row_t R100  = {8'd100, 8'd100, 8'd100, 8'd100};
  localparam row_t R0    = {8'd0,   8'd0,   8'd0,   8'd0};
  localparam row_t R255  = {8'd255, 8'd255, 8'd255, 8'd255};
  localparam row_t RSTEP = {8'd0,   8'd0,   8'd10,  8'd10};
  localparam row_t R50   = {8'd0,   8'd0,   8'd50,  8'd50};
  localparam row_t RR60  = {8'd0,   8'd60,  8'd120, 8'd180};
  localparam row_t RR70  = {8'd0,   8'd70,  8'd140, 8'd210};

  vec_t   vecs[8];
  frame_t test2;
  frame_t stepf;
  logic [PW-1:0] held;
  bit     seen;

  initial begin
    // Hand-computed magnitudes, SHIFT=1:
    //   {0,0,10,10}  gx=40          -> 20
    //   {0,0,50,50}  gx=200         -> 100
    //   255/0 step   gy=-1020       -> 510 -> 255
    //   10r+10c      gx=80, gy=80   -> 80
    //   30-10c+10r   gx=-80, gy=80  -> 80
    //   60-ramp      gx=480         -> 240
    //   70-ramp      gx=560         -> 280 -> 255
    test2 = rows(RSTEP, RSTEP, RSTEP, RSTEP);
    stepf = rows(R255, R255, R0, R0);
    vecs[0] = mk("flat100", rows(R100, R100, R100, R100), 8'd0);
    vecs[1] = mk("colstep", test2, 8'd20);
    vecs[2] = mk("colstep50", rows(R50, R50, R50, R50), 8'd100);
    vecs[3] = mk("rowstep", stepf, 8'd255);
    vecs[4] = mk("diag", rows({8'd0, 8'd10, 8'd20, 8'd30}, {8'd10, 8'd20, 8'd30, 8'd40},
                              {8'd20, 8'd30, 8'd40, 8'd50}, {8'd30, 8'd40, 8'd50, 8'd60}), 8'd80);
    vecs[5] = mk("antidiag", rows({8'd30, 8'd20, 8'd10, 8'd0}, {8'd40, 8'd30, 8'd20, 8'd10},
                                  {8'd50, 8'd40, 8'd30, 8'd20}, {8'd60, 8'd50, 8'd40, 8'd30}), 8'd80);
    vecs[6] = mk("ramp60", rows(RR60, RR60, RR60, RR60), 8'd240);
    vecs[7] = mk("ramp70", rows(RR70, RR70, RR70, RR70), 8'd255);

    reset        = 1'b1;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b1;
`ifdef SOBEL_THRESH_EN
    threshold    = 8'd100;
`endif
    clear_capture();

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    check("rst_out_valid", out_if.valid, 0);
    check("rst_out_data", out_if.data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_in_ready", in_if.ready, 1);
    reset = 1'b0;

    // Table of single frames, full-rate sink
    for (int v = 0; v < 8; v++) begin
      clear_capture();
      send_frame(vecs[v].pix, 16);
      go_idle();
      drain();
      check({vecs[v].name, "_count"}, got_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("%s_out%0d", vecs[v].name, i),
              (i < got_q.size()) ? int'(got_q[i]) : -1, xf(int'(vecs[v].exp[i])));
        check($sformatf("%s_lat%0d", vecs[v].name, i),
              (i < got_cyc.size() && i < acc_cyc.size()) ? int'(got_cyc[i] - acc_cyc[i]) : -1, 1);
      end
      check({vecs[v].name, "_frame_done"}, fd_cnt, 1);
      check({vecs[v].name, "_fd_align"}, int'(fd_cyc),
            (got_cyc.size() == 4) ? int'(got_cyc[3]) : -1);
    end

    // Stall: out_ready low 5 cycles starting with the first out_valid
    clear_capture();
    seen = 1'b0;
    fork
      begin
        send_frame(test2, 16);
        go_idle();
      end
      begin
        for (int t = 0; t < 200 && !seen; t++) begin
          @(negedge clock);
          if (out_if.valid) seen = 1'b1;
        end
        if (!seen) begin
          fail("stall_wait_valid");
        end else begin
          out_if.ready = 1'b0;
          held = out_if.data;
          for (int s = 0; s < 5; s++) begin
            #1;
            check($sformatf("stall_in_ready%0d", s), in_if.ready, 0);
            check($sformatf("stall_valid%0d", s), out_if.valid, 1);
            check($sformatf("stall_hold%0d", s), out_if.data, held);
            @(negedge clock);
          end
          out_if.ready = 1'b1;
        end
      end
    join
    drain();
    check_outputs("stall", 4, xf(20));
    check("stall_frame_done", fd_cnt, 1);

    // Frame boundary: step frame immediately followed by the test-2 frame
    clear_capture();
    send_frame(stepf, 16);
    send_frame(test2, 16);
    go_idle();
    drain();
    check("b2b_count", got_q.size(), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("b2b_out%0d", i), (i < got_q.size()) ? int'(got_q[i]) : -1,
            (i < 4) ? xf(255) : xf(20));
    check("b2b_frame_done", fd_cnt, 2);

    // Reset after 6 accepts, then a clean frame
    clear_capture();
    send_frame(vecs[7].pix, 6);
    @(negedge clock);
    in_if.valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    clear_capture();
    send_frame(test2, 16);
    go_idle();
    drain();
    check_outputs("rst6", 4, xf(20));
    check("rst6_frame_done", fd_cnt, 1);

    // Reset with an output pending behind a stalled sink
    clear_capture();
    out_if.ready = 1'b0;
    send_frame(vecs[7].pix, 11);
    @(negedge clock);
    in_if.valid = 1'b0;
    #1;
    check("pend_valid", out_if.valid, 1);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("pend_rst_valid", out_if.valid, 0);
    check("pend_rst_data", out_if.data, 0);
    reset = 1'b0;
    out_if.ready = 1'b1;
    clear_capture();
    send_frame(test2, 16);
    go_idle();
    drain();
    check_outputs("pend", 4, xf(20));

`ifdef SOBEL_THRESH_EN
    // Threshold at and just above the magnitude
    threshold = 8'd20;
    clear_capture();
    send_frame(test2, 16);
    go_idle();
    drain();
    check_outputs("thr20", 4, 255);
    threshold = 8'd21;
    clear_capture();
    send_frame(test2, 16);
    go_idle();
    drain();
    check_outputs("thr21", 4, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
